// File: rtl/cdb_pkg.sv
// Shared constants and helpers for the CDB write-back arbiter.
package cdb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned NUM_CDB = 2;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REQ_W   = $clog2(NUM_REQ);

  typedef logic [REQ_W-1:0] req_id_t;

  localparam req_id_t REQ_FXU0   = req_id_t'(0);
  localparam req_id_t REQ_FXU1   = req_id_t'(1);
  localparam req_id_t REQ_LSU    = req_id_t'(2);
  localparam req_id_t REQ_BRANCH = req_id_t'(3);

  // Distance of a ROB entry from the head; wraps through IDX_W-bit truncation.
  function automatic logic [IDX_W-1:0] rob_age(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/cdb_pick_first.sv
// Finds the lowest set bit of a NUM_REQ-wide request vector.
module cdb_pick_first
  import cdb_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec_i,
  output logic               found_o,
  output req_id_t            pos_o
);

  always_comb begin
    found_o = 1'b0;
    pos_o   = '0;
    // Descending scan so the lowest set bit is the final assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        pos_o   = req_id_t'(i);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB write-back arbiter: grants up to NUM_CDB results per cycle and registers them onto the CDB.
// Round-robin by default; define CDB_AGE_PRIORITY_EN to grant the oldest ROB entries first.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [IDX_W-1:0]           rob_head_idx,
  input  logic [NUM_REQ-1:0]         req_valid_flat,
  input  logic [NUM_REQ*IDX_W-1:0]   req_idx_flat,
  input  logic [NUM_REQ*DATA_W-1:0]  req_value_flat,
  output logic [NUM_REQ-1:0]         req_ready_flat,
  output logic [NUM_CDB-1:0]         cdb_valid_flat,
  output logic [NUM_CDB*IDX_W-1:0]   cdb_idx_flat,
  output logic [NUM_CDB*DATA_W-1:0]  cdb_value_flat
);

  function automatic req_id_t rr_add(input req_id_t a, input req_id_t b);
    int s;
    s = int'(a) + int'(b);
    if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
    return req_id_t'(s);
  endfunction

  // Keeps only the oldest candidates of v; ties resolve to the lower requester.
  function automatic logic [NUM_REQ-1:0] oldest_mask(
    input logic [NUM_REQ-1:0]            v,
    input logic [NUM_REQ-1:0][IDX_W-1:0] ages
  );
    logic [NUM_REQ-1:0] m;
    m = v;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (v[j] && (ages[j] < ages[i] || (ages[j] == ages[i] && j < i))) m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  logic [NUM_REQ-1:0] req_valid;
  logic [IDX_W-1:0]   req_idx   [NUM_REQ];
  logic [DATA_W-1:0]  req_value [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = req_valid_flat[NUM_REQ-1-i];
      req_idx[i]   = req_idx_flat[(NUM_REQ-1-i)*IDX_W +: IDX_W];
      req_value[i] = req_value_flat[(NUM_REQ-1-i)*DATA_W +: DATA_W];
    end
  end

  req_id_t rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] base_valid;

`ifdef CDB_AGE_PRIORITY_EN
  logic [NUM_REQ-1:0][IDX_W-1:0] age;
  logic unused_rr_ptr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) age[i] = rob_age(req_idx[i], rob_head_idx);
  end

  assign base_valid    = req_valid;
  assign unused_rr_ptr = ^rr_ptr_q;
`else
  logic unused_head;

  // Rotated so that slot 0 is the requester rr_ptr points at.
  always_comb begin
    base_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) base_valid[j] = req_valid[rr_add(rr_ptr_q, req_id_t'(j))];
  end

  assign unused_head = ^rob_head_idx;
`endif

  logic    found  [NUM_CDB];
  req_id_t win_id [NUM_CDB];

  for (genvar k = 0; k < NUM_CDB; k++) begin : g_stage
    logic [NUM_REQ-1:0] avail;
    logic [NUM_REQ-1:0] cand;
    logic               stage_found;
    req_id_t            pos;

    if (k == 0) begin : g_first
      assign avail = base_valid;
    end else begin : g_next
      assign avail = g_stage[k-1].avail &
                     ~({{(NUM_REQ-1){1'b0}}, g_stage[k-1].stage_found} << g_stage[k-1].pos);
    end

`ifdef CDB_AGE_PRIORITY_EN
    assign cand      = oldest_mask(avail, age);
    assign win_id[k] = pos;
`else
    assign cand      = avail;
    assign win_id[k] = rr_add(rr_ptr_q, pos);
`endif

    cdb_pick_first u_pick (
      .vec_i   (cand),
      .found_o (stage_found),
      .pos_o   (pos)
    );

    assign found[k] = stage_found;
  end

  logic [NUM_REQ-1:0] grant;

  always_comb begin
    grant = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (found[k]) grant[win_id[k]] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_flat[NUM_REQ-1-i] = grant[i] & ~flush & rst_n;
    end
  end

  logic [NUM_CDB-1:0] cdb_valid_q, cdb_valid_d;
  logic [IDX_W-1:0]   cdb_idx_q   [NUM_CDB];
  logic [IDX_W-1:0]   cdb_idx_d   [NUM_CDB];
  logic [DATA_W-1:0]  cdb_value_q [NUM_CDB];
  logic [DATA_W-1:0]  cdb_value_d [NUM_CDB];

  always_comb begin
    cdb_valid_d = '0;
    cdb_idx_d   = cdb_idx_q;
    cdb_value_d = cdb_value_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (found[k]) begin
          cdb_valid_d[k] = 1'b1;
          cdb_idx_d[k]   = req_idx[win_id[k]];
          cdb_value_d[k] = req_value[win_id[k]];
          rr_ptr_d       = rr_add(win_id[k], req_id_t'(1));
        end
      end
    end
`ifdef CDB_AGE_PRIORITY_EN
    rr_ptr_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      for (int p = 0; p < NUM_CDB; p++) begin
        cdb_idx_q[p]   <= '0;
        cdb_value_q[p] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_idx_q   <= cdb_idx_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb_valid_flat[NUM_CDB-1-p]                    = cdb_valid_q[p];
      cdb_idx_flat[(NUM_CDB-1-p)*IDX_W +: IDX_W]     = cdb_idx_q[p];
      cdb_value_flat[(NUM_CDB-1-p)*DATA_W +: DATA_W] = cdb_value_q[p];
    end
  end

endmodule
